// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns ID, EX multicycle and MEM wait hazards into a
// prioritised stall bus, and holds a branch taken during a PC stall until the PC can move.
module pipe_ctrl #(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_mc_start,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        be_in,
    input  logic [31:0] baddr_in,
    output logic [5:0]  ctrl_stall,
    output logic        be,
    output logic [31:0] baddr,
    output logic        flush,
    output logic        ex_done,
    output logic        mem_err,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EX_WAIT  = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    // The EX counter runs from MUL_CYCLES-2 down to 0; zero is the ex_done cycle.
    localparam logic [3:0] EX_LOAD = 4'(MUL_CYCLES - 2);
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  ex_cnt_q, ex_cnt_d;
    logic        ex_pend_q, ex_pend_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        mem_stall;
    logic        ex_stall;
    logic        done_c;
    logic        err_c;
    logic        timeout;
    logic [5:0]  stall_pat;
    logic        be_c;

    assign timeout = (wait_q == TIMEOUT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wait_q       <= 8'd0;
            ex_cnt_q     <= 4'd0;
            ex_pend_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            ex_cnt_q     <= ex_cnt_d;
            ex_pend_q    <= ex_pend_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ex_cnt_d  = ex_cnt_q;
        ex_pend_d = ex_pend_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d   = S_MEM_WAIT;
                    wait_d    = 8'd0;
                    ex_pend_d = ex_mc_start;
                end else if (ex_mc_start) begin
                    state_d  = S_EX_WAIT;
                    ex_cnt_d = EX_LOAD;
                end
            end
            S_EX_WAIT: begin
                if (ex_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    ex_cnt_d = ex_cnt_q - 4'd1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ack || timeout) begin
                    // A multicycle op that arrived behind the MEM stall starts from its full length.
                    if (ex_pend_q) begin
                        state_d   = S_EX_WAIT;
                        ex_cnt_d  = EX_LOAD;
                        ex_pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: hazard sources from registered state plus current inputs
    always_comb begin
        mem_stall = 1'b0;
        ex_stall  = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_stall = mem_req && !mem_ack;
                ex_stall  = ex_mc_start;
            end
            S_EX_WAIT: begin
                ex_stall = (ex_cnt_q != 4'd0);
                done_c   = (ex_cnt_q == 4'd0);
            end
            S_MEM_WAIT: begin
                mem_stall = !mem_ack && !timeout;
                err_c     = !mem_ack && timeout;
                ex_stall  = ex_pend_q;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase

        if (mem_stall) begin
            stall_pat = STALL_MEM;
        end else if (ex_stall) begin
            stall_pat = STALL_EX;
        end else if (stallreq_id) begin
            stall_pat = STALL_ID;
        end else begin
            stall_pat = STALL_NONE;
        end
    end

    // Branch hold: the first branch seen while the PC is frozen is kept until the PC moves.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (pend_valid_q && !stall_pat[0]) begin
            pend_valid_d = 1'b0;
        end else if (!pend_valid_q && be_in && stall_pat[0]) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = baddr_in;
        end
    end

    assign be_c = be_in || pend_valid_q;

    // Every output is forced low while reset is held, whatever the inputs do.
    assign ctrl_stall  = rst ? stall_pat : STALL_NONE;
    assign be          = rst && be_c;
    assign baddr       = rst ? (pend_valid_q ? pend_addr_q : baddr_in) : 32'h0;
    assign flush       = rst && be_c && !stall_pat[0];
    assign ex_done     = rst && done_c;
    assign mem_err     = rst && err_c;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios followed by random traffic, every cycle
// compared against a cycle-count model of the stall/branch rules.
module tb_pipe_ctrl;

    localparam int MUL = 4;
    localparam int MTO = 15;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic        mem_req;
    logic        mem_ack;
    logic        be_in;
    logic [31:0] baddr_in;
    logic [5:0]  ctrl_stall;
    logic        be;
    logic [31:0] baddr;
    logic        flush;
    logic        ex_done;
    logic        mem_err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: remaining EX cycles (last one is the done cycle), MEM wait count (-1 = none)
    int          m_ex_left  = 0;
    int          m_mem_cnt  = -1;
    bit          m_pend     = 0;
    logic [31:0] br_q[$];

    logic obs_done;
    logic obs_err;

    pipe_ctrl #(.MUL_CYCLES(MUL), .MEM_TIMEOUT(MTO)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .ex_mc_start (ex_mc_start),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .be_in       (be_in),
        .baddr_in    (baddr_in),
        .ctrl_stall  (ctrl_stall),
        .be          (be),
        .baddr       (baddr),
        .flush       (flush),
        .ex_done     (ex_done),
        .mem_err     (mem_err),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        stallreq_id = 1'b0;
        ex_mc_start = 1'b0;
        mem_req     = 1'b0;
        mem_ack     = 1'b0;
        be_in       = 1'b0;
        baddr_in    = 32'h0;
    endtask

    // Called at a falling edge with inputs already set; compares, then advances one clock.
    task automatic cycle();
        logic [5:0]  e_stall;
        logic [31:0] e_baddr;
        bit e_be, e_flush, e_done, e_err;
        bit mem_s, ex_s, complete;
        int n_ex, n_mem;
        bit n_pend;
        e_stall = 6'd0; e_baddr = 32'h0;
        e_be = 0; e_flush = 0; e_done = 0; e_err = 0;
        mem_s = 0; ex_s = 0; complete = 0;
        n_ex = m_ex_left; n_mem = m_mem_cnt; n_pend = m_pend;
        if (!rst) begin
            n_ex = 0; n_mem = -1; n_pend = 0;
            br_q.delete();
        end else begin
            if (m_mem_cnt >= 0) begin
                if (mem_ack) begin
                    complete = 1;
                end else if (m_mem_cnt == MTO) begin
                    complete = 1;
                    e_err = 1;
                end else begin
                    mem_s = 1;
                    n_mem = m_mem_cnt + 1;
                end
                if (complete) begin
                    n_mem = -1;
                    if (m_pend) begin
                        ex_s = 1;
                        n_ex = MUL - 1;
                        n_pend = 0;
                    end
                end
            end else if (m_ex_left > 0) begin
                if (m_ex_left == 1) e_done = 1;
                else ex_s = 1;
                n_ex = m_ex_left - 1;
            end else begin
                if (mem_req && !mem_ack) begin
                    mem_s = 1;
                    n_mem = 0;
                    n_pend = ex_mc_start;
                end else if (ex_mc_start) begin
                    ex_s = 1;
                    n_ex = MUL - 1;
                end
            end
            e_stall = mem_s ? 6'b011111 : ex_s ? 6'b001111 : stallreq_id ? 6'b000111 : 6'b000000;
            e_be    = be_in || (br_q.size() > 0);
            e_baddr = (br_q.size() > 0) ? br_q[0] : baddr_in;
            e_flush = e_be && !e_stall[0];
        end

        #2;
        check("ctrl_stall", 32'(ctrl_stall), 32'(e_stall));
        check("be", 32'(be), 32'(e_be));
        check("baddr", baddr, e_baddr);
        check("flush", 32'(flush), 32'(e_flush));
        check("ex_done", 32'(ex_done), 32'(e_done));
        check("mem_err", 32'(mem_err), 32'(e_err));
        obs_done = ex_done;
        obs_err  = mem_err;

        @(posedge clk);
        m_ex_left = n_ex;
        m_mem_cnt = n_mem;
        m_pend    = n_pend;
        if (rst) begin
            if (br_q.size() > 0 && !e_stall[0]) begin
                void'(br_q.pop_front());
            end else if (br_q.size() == 0 && be_in && e_stall[0]) begin
                br_q.push_back(baddr_in);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int lat;
        int pulses;
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        stallreq_id = 1'b1; mem_req = 1'b1; be_in = 1'b1; baddr_in = 32'hdead_beef;
        cycle();
        cycle();
        idle_inputs();
        rst = 1'b1;
        run_idle(2);

        // ID hazard for a single cycle
        stallreq_id = 1'b1;
        cycle();
        run_idle(2);

        // EX multicycle: done latency from the start cycle
        ex_mc_start = 1'b1;
        cycle();
        ex_mc_start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (obs_done && lat < 0) lat = k;
        end
        check("ex_done_latency", 32'(lat), 32'(MUL - 1));

        // MEM wait acknowledged in the fourth cycle
        mem_req = 1'b1;
        cycle(); cycle(); cycle();
        mem_ack = 1'b1;
        cycle();
        run_idle(2);

        // MEM timeout: single mem_err pulse 16 cycles after entry
        mem_req = 1'b1;
        cycle();
        mem_req = 1'b0;
        lat = -1;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (obs_err) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        check("mem_err_latency", 32'(lat), 32'(MTO + 1));
        check("mem_err_pulses", 32'(pulses), 32'd1);

        // Branch taken during an EX stall is held until the PC moves
        ex_mc_start = 1'b1;
        cycle();
        ex_mc_start = 1'b0;
        be_in = 1'b1; baddr_in = 32'h0000_0100;
        cycle();
        be_in = 1'b0; baddr_in = 32'h0000_0200;
        cycle(); cycle(); cycle();
        run_idle(2);

        // EX start behind a MEM stall, then reset in the middle of EX_WAIT
        ex_mc_start = 1'b1; mem_req = 1'b1;
        cycle();
        ex_mc_start = 1'b0; mem_req = 1'b0;
        cycle(); cycle();
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        cycle();
        stallreq_id = 1'b1; be_in = 1'b1; baddr_in = 32'h1234_5678; mem_req = 1'b1; ex_mc_start = 1'b1;
        rst = 1'b0;
        cycle();
        idle_inputs();
        rst = 1'b1;
        run_idle(6);

        // Random traffic; ack rarely arrives in some phases to reach the timeout
        for (int blk = 0; blk < 15; blk++) begin
            int ack_pct;
            ack_pct = (blk % 3 == 2) ? 2 : 35;
            for (int i = 0; i < 200; i++) begin
                rst         = ($urandom_range(0, 299) != 0);
                stallreq_id = ($urandom_range(0, 3) == 0);
                ex_mc_start = ($urandom_range(0, 7) == 0);
                mem_req     = ($urandom_range(0, 4) == 0);
                mem_ack     = ($urandom_range(0, 99) < ack_pct);
                be_in       = ($urandom_range(0, 4) == 0);
                baddr_in    = $urandom;
                cycle();
            end
        end
        rst = 1'b1;
        run_idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4, giving the EX multicycle operation length in cycles; legal range is 2..15.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum number of MEM_WAIT cycles without mem_ack; legal range is 1..255.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have the port stallreq_id, input, 1 bit: ID load-use hazard, level.
REQ-006 The block SHALL have the port ex_mc_start, input, 1 bit: single-cycle pulse marking the start of an EX multicycle operation.
REQ-007 The block SHALL have the port mem_req, input, 1 bit: MEM stage data access request, level.
REQ-008 The block SHALL have the port mem_ack, input, 1 bit: memory ready/acknowledge.
REQ-009 The block SHALL have the port be_in, input, 1 bit: branch taken, from ID.
REQ-010 The block SHALL have the port baddr_in, input, 32 bits: branch target.
REQ-011 The block SHALL have the port ctrl_stall, output, 6 bits: stall bus, one bit per stage (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB); 1 means hold.
REQ-012 The block SHALL have the port be, output, 1 bit: branch enable to the PC.
REQ-013 The block SHALL have the port baddr, output, 32 bits: branch target to the PC.
REQ-014 The block SHALL have the port flush, output, 1 bit: IF/ID flush.
REQ-015 The block SHALL have the port ex_done, output, 1 bit: pulse marking the final cycle of an EX multicycle operation.
REQ-016 The block SHALL have the port mem_err, output, 1 bit: pulse signalling a MEM_WAIT timeout.

Function
REQ-017 The block SHALL implement the states IDLE, EX_WAIT and MEM_WAIT, encoded in a registered state variable.
REQ-018 The block SHALL drive ctrl_stall combinationally from the current state and inputs, using a single pattern chosen by priority MEM > EX > ID: MEM = 6'b011111, EX = 6'b001111, ID = 6'b000111, none = 6'b000000.
REQ-019 When in IDLE with mem_req=1 and mem_ack=0, the block SHALL output the MEM stall pattern in that same cycle and enter MEM_WAIT on the next edge.
REQ-020 When in IDLE with mem_req=1 and mem_ack=1, the block SHALL produce no MEM stall and remain in IDLE.
REQ-021 In MEM_WAIT, the block SHALL output the MEM stall pattern on every cycle in which mem_ack=0.
REQ-022 In MEM_WAIT, in the cycle where mem_ack=1 the block SHALL drop the MEM stall and return to IDLE on the next edge.
REQ-023 In MEM_WAIT, the block SHALL maintain a wait counter that clears on MEM_WAIT entry and increments on each MEM_WAIT cycle with mem_ack=0.
REQ-024 When the wait counter equals MEM_TIMEOUT, the block SHALL assert mem_err for 1 cycle, drop the MEM stall in that cycle, and return to IDLE; mem_ack arriving in the same cycle SHALL take precedence and suppress mem_err.
REQ-025 When in IDLE with ex_mc_start=1 at cycle T and no MEM stall, the block SHALL output the EX stall pattern in cycles T through T+MUL_CYCLES-2.
REQ-026 For the EX operation started at cycle T, the block SHALL pulse ex_done and drop the EX stall in cycle T+MUL_CYCLES-1, using EX_WAIT with a 4-bit down-counter.
REQ-027 When ex_mc_start and a MEM stall occur in the same IDLE cycle, the block SHALL latch ex_mc_start into an ex_pend flag.
REQ-028 When the MEM wait completes (ack or timeout), the block SHALL go to EX_WAIT with the full MUL_CYCLES count taken from ex_pend, keep the EX stall asserted through the transition cycle, and clear ex_pend.
REQ-029 The block SHALL ignore ex_mc_start while in EX_WAIT.
REQ-030 The block SHALL assert the ID stall pattern only when stallreq_id=1 and neither the MEM nor the EX stall is active.
REQ-031 When be_in=1 in a cycle with ctrl_stall[0]=1, the block SHALL capture baddr_in into a pending register and set pend_valid; a later be_in SHALL NOT overwrite a valid pending entry.
REQ-032 The block SHALL drive be = be_in OR pend_valid and baddr = pend_valid ? pend_addr : baddr_in.
REQ-033 The block SHALL clear pend_valid at the edge ending the first cycle with ctrl_stall[0]=0.
REQ-034 The block SHALL drive flush = be AND NOT ctrl_stall[0], combinationally.
REQ-035 The block SHALL add no latency to stall assertion; stall decisions SHALL be combinational from registered state plus current inputs.

Reset
REQ-036 While rst=0, the block SHALL asynchronously force state=IDLE and clear the wait counter, the EX counter, ex_pend, pend_valid and pend_addr (to 32'h0).
REQ-037 While in reset, the block SHALL drive ctrl_stall=6'b000000 and be, baddr, flush, ex_done and mem_err to 0 regardless of inputs.
REQ-038 When reset is asserted mid-operation (EX_WAIT or MEM_WAIT), the block SHALL abandon the operation with no ex_done or mem_err pulse.
REQ-039 The block SHALL leave reset on the first rising clk edge after rst returns to 1.

Verification
REQ-040 The bench SHALL cover: stallreq_id=1 for 1 cycle -> ctrl_stall=000111 in that cycle, 000000 in the next.
REQ-041 The bench SHALL cover: ex_mc_start pulse at T with MUL_CYCLES=4 -> ctrl_stall=001111 in T, T+1, T+2; ex_done=1 and ctrl_stall=000000 in T+3.
REQ-042 The bench SHALL cover: mem_req=1 with mem_ack rising at T+3 -> ctrl_stall=011111 in T..T+2 and 000000 in T+3, with no mem_err.
REQ-043 The bench SHALL cover: mem_req=1, mem_ack held at 0, MEM_TIMEOUT=15 -> mem_err is a single-cycle pulse 16 cycles after entry and the state returns to IDLE.
REQ-044 The bench SHALL cover: be_in=1 with baddr_in=32'h0000_0100 during an EX stall, then be_in=0 -> be=1 and baddr=32'h100 in the first unstalled cycle with flush=1, and be=0 one cycle later.
REQ-045 The bench SHALL cover: ex_mc_start and mem_req with mem_ack=0 in the same cycle -> the MEM stall first, then the full EX stall sequence after mem_ack; rst=0 asserted mid-EX_WAIT -> all outputs 0 immediately.
